mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Multi-cycle multiply/divide unit for the EX stage. It complements the single-cycle ALU by executing MULT/MULTU/DIV/DIVU iteratively into the architectural HI/LO registers, and services MTHI/MTLO writes. The pipeline issues a request with `start`, stalls while `busy` is high, and reads `hi`/`lo` directly (MFHI/MFLO).

## Interface

Parameters:
- none (32-bit datapath fixed; operands are the codebase `Vec32` type)

Ports:
- `clk`  in  1  clock; all state changes on the rising edge
- `resetN`  in  1  asynchronous, active-low reset
- `mdInput1`  in  32  rs operand: dividend / multiplicand / MTHI-MTLO data
- `mdInput2`  in  32  rt operand: divisor / multiplier
- `mdOp`  in  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved (no action)
- `start`  in  1  request valid; sampled only in IDLE
- `flush`  in  1  cancel the in-flight operation (exception/branch flush)
- `busy`  out  1  high while an operation is in flight (state != IDLE); combinational from state
- `done`  out  1  registered single-cycle pulse when HI/LO are written by a mul/div
- `hi`  out  32  HI register
- `lo`  out  32  LO register

## Operation

- States: IDLE, RUN, FIXUP.
- IDLE, `start`=1, `flush`=0:
  - mdOp 0-3: latch operand magnitudes (two's-complement abs for MULT/DIV, raw for MULTU/DIVU), the sign bits, and the op; clear the 5-bit iteration counter; go to RUN.
  - mdOp 4/5: write `mdInput1` into `hi`/`lo` at this edge; stay in IDLE; no `done`.
  - mdOp 6/7: no effect.
- RUN: one bit per cycle for 32 cycles. Multiply is shift-add into a 64-bit accumulator. Divide is radix-2 restoring (remainder shift, trial subtract, quotient bit). After the 32nd iteration go to FIXUP.
- FIXUP: apply sign correction, write `hi`/`lo`, pulse `done`, return to IDLE.
  - MULT/MULTU: {hi,lo} = 64-bit product; for MULT, negate the product if the operand signs differ.
  - DIV/DIVU: lo = quotient, hi = remainder. For DIV, the quotient is negated if the signs differ and the remainder takes the dividend's sign.
  - Divide by zero (DIV or DIVU): lo = 0xFFFFFFFF, hi = raw `mdInput1`, with no sign correction.
  - DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- `start` while busy is ignored, including MTHI/MTLO. The pipeline must hold these requests until `busy` is low.
- `flush`:
  - In RUN or FIXUP: return to IDLE at the next edge; `hi`/`lo` are unchanged and `done` is not asserted. Flush overrides the FIXUP write.
  - In IDLE: suppresses `start`, including MTHI/MTLO.
- Reset (`resetN`=0, any time including mid-operation): state IDLE, `hi`=0, `lo`=0, `done`=0, internal accumulators cleared, `busy`=0 immediately.

## Timing

- Accept edge E0 (IDLE, start=1): `busy`=1 from just after E0.
- Iteration edges E1..E32; the state is FIXUP after E32.
- Edge E33: `hi`/`lo` updated, `done`=1, `busy`=0.
- `done` falls at E34 unless a new operation completes there (impossible, minimum spacing 34 cycles).
- Fixed latency: result visible 33 cycles after the accept edge, independent of operand values. There is no early termination.
- A new `start` is accepted at E33 itself? No: at E33 the state is still FIXUP. The earliest next accept is E34. Back-to-back throughput is one mul/div per 34 cycles.
- MTHI/MTLO take effect at the accept edge, with zero busy cycles.
- `hi`/`lo` hold their values at all times except the FIXUP edge, MTHI/MTLO edges, and reset.

## Test plan

- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. `busy` high for exactly 33 cycles; `done` is a one-cycle pulse at E33.
- MULT -3 × 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT 0x80000000 × 0x80000000 -> hi=0x40000000, lo=0.
- DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100 / 7 -> lo=14, hi=2. DIV 0x80000000 / -1 -> lo=0x80000000, hi=0.
- DIVU 100 / 0 -> lo=0xFFFFFFFF, hi=0x00000064. DIV -5 / 0 -> lo=0xFFFFFFFF, hi=0xFFFFFFFB.
- Start DIVU. Assert `flush` in cycle 10 and again in the FIXUP cycle of a second op -> `busy` falls the next edge, hi/lo keep their prior values, no `done`. A following MTLO 0x1234 is accepted immediately: lo=0x1234, busy stays 0.
- Start MULT, drop `resetN` mid-RUN -> outputs go to zero / IDLE immediately. A start while busy (MTHI 0xAAAA) -> ignored, `hi` unchanged.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit feeding HI/LO.
// Shift-add multiply, restoring divide, fixed 34-cycle turnaround.
module mul_div_unit (
  input  logic        clk,
  input  logic        resetN,
  input  logic [31:0] mdInput1,
  input  logic [31:0] mdInput2,
  input  logic [2:0]  mdOp,
  input  logic        start,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIXUP
  } state_t;

  state_t      state;
  state_t      stateNext;
  logic [63:0] acc;
  logic [31:0] aMag;
  logic [31:0] bMag;
  logic        negA;
  logic        negB;
  logic [1:0]  op;
  logic [4:0]  cnt;

  logic        sgnIn;
  logic        negIn1;
  logic        negIn2;
  logic [31:0] magIn1;
  logic [31:0] magIn2;
  logic        isDiv;
  logic [32:0] mulSum;
  logic [63:0] mulNext;
  logic [32:0] divDiff;
  logic [63:0] divNext;
  logic [31:0] resHi;
  logic [31:0] resLo;

  assign busy   = (state != IDLE);
  assign isDiv  = op[1];

  assign sgnIn  = ~mdOp[0];
  assign negIn1 = sgnIn & mdInput1[31];
  assign negIn2 = sgnIn & mdInput2[31];
  assign magIn1 = negIn1 ? -mdInput1 : mdInput1;
  assign magIn2 = negIn2 ? -mdInput2 : mdInput2;

  // Multiplier sits in acc[31:0] and retires from the bottom.
  assign mulSum  = {1'b0, acc[63:32]} + {1'b0, aMag};
  assign mulNext = acc[0] ? {mulSum, acc[31:1]}
                          : {1'b0, acc[63:1]};

  // acc = {remainder, dividend/quotient}.
  assign divDiff = acc[63:31] - {1'b0, bMag};
  assign divNext = divDiff[32] ? {acc[62:0], 1'b0}
                               : {divDiff[31:0], acc[30:0], 1'b1};

  always_comb begin
    resHi = acc[63:32];
    resLo = acc[31:0];
    if (!isDiv) begin
      {resHi, resLo} = (negA ^ negB) ? -acc : acc;
    end else if (bMag == 32'd0) begin
      resLo = 32'hFFFF_FFFF;
      resHi = negA ? -aMag : aMag;
    end else begin
      resLo = (negA ^ negB) ? -acc[31:0] : acc[31:0];
      resHi = negA ? -acc[63:32] : acc[63:32];
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (start && !flush && !mdOp[2]) stateNext = RUN;
      end
      RUN: begin
        if (flush)             stateNext = IDLE;
        else if (cnt == 5'd31) stateNext = FIXUP;
      end
      FIXUP:   stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= stateNext;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      acc  <= '0;
      aMag <= '0;
      bMag <= '0;
      negA <= 1'b0;
      negB <= 1'b0;
      op   <= '0;
      cnt  <= '0;
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !flush) begin
            unique case (1'b1)
              !mdOp[2]: begin
                aMag <= magIn1;
                bMag <= magIn2;
                negA <= negIn1;
                negB <= negIn2;
                op   <= mdOp[1:0];
                cnt  <= '0;
                acc  <= mdOp[1] ? {32'd0, magIn1}
                                : {32'd0, magIn2};
              end
              (mdOp == 3'd4): hi <= mdInput1;
              (mdOp == 3'd5): lo <= mdInput1;
              default: ;
            endcase
          end
        end
        RUN: begin
          if (!flush) begin
            acc <= isDiv ? divNext : mulNext;
            cnt <= cnt + 5'd1;
          end
        end
        FIXUP: begin
          if (!flush) begin
            hi   <= resHi;
            lo   <= resLo;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: results, latency, flush,
// reset and busy-time request handling.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        resetN;
  logic [31:0] mdInput1;
  logic [31:0] mdInput2;
  logic [2:0]  mdOp;
  logic        start;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int total  = 0;
  int passed = 0;

  mul_div_unit dut (
    .clk      (clk),
    .resetN   (resetN),
    .mdInput1 (mdInput1),
    .mdInput2 (mdInput2),
    .mdOp     (mdOp),
    .start    (start),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic issue(input logic [2:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clk);
    mdOp     = op;
    mdInput1 = a;
    mdInput2 = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic runOp(input string tag,
                       input logic [2:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [31:0] expHi,
                       input logic [31:0] expLo);
    int k;
    issue(op, a, b);
    k = 0;
    while (busy && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    check({tag, " busyCycles"}, 64'(k), 64'd33);
    check({tag, " done"}, 64'(done), 64'd1);
    check({tag, " hi"}, 64'(hi), 64'(expHi));
    check({tag, " lo"}, 64'(lo), 64'(expLo));
    @(posedge clk);
    #1;
    check({tag, " doneFall"}, 64'(done), 64'd0);
  endtask

  initial begin
    resetN   = 1'b0;
    mdInput1 = '0;
    mdInput2 = '0;
    mdOp     = '0;
    start    = 1'b0;
    flush    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst hi", 64'(hi), 64'd0);
    check("rst lo", 64'(lo), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    @(negedge clk);
    resetN = 1'b1;

    runOp("multu max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          32'hFFFF_FFFE, 32'h0000_0001);
    runOp("mult -3x7", 3'd0, 32'hFFFF_FFFD, 32'd7,
          32'hFFFF_FFFF, 32'hFFFF_FFEB);
    runOp("mult minxmin", 3'd0, 32'h8000_0000, 32'h8000_0000,
          32'h4000_0000, 32'h0000_0000);
    runOp("div -7/2", 3'd2, 32'hFFFF_FFF9, 32'd2,
          32'hFFFF_FFFF, 32'hFFFF_FFFD);
    runOp("divu 100/7", 3'd3, 32'd100, 32'd7,
          32'd2, 32'd14);
    runOp("div min/-1", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF,
          32'h0000_0000, 32'h8000_0000);
    runOp("divu 100/0", 3'd3, 32'd100, 32'd0,
          32'h0000_0064, 32'hFFFF_FFFF);
    runOp("div -5/0", 3'd2, 32'hFFFF_FFFB, 32'd0,
          32'hFFFF_FFFB, 32'hFFFF_FFFF);

    // flush in RUN, cycle 10
    issue(3'd3, 32'd50, 32'd3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flushRun busy", 64'(busy), 64'd0);
    check("flushRun done", 64'(done), 64'd0);
    check("flushRun hi", 64'(hi), 64'hFFFF_FFFB);
    check("flushRun lo", 64'(lo), 64'hFFFF_FFFF);

    // flush in FIXUP
    issue(3'd3, 32'd50, 32'd3);
    repeat (32) @(posedge clk);
    #1;
    check("fixup busy", 64'(busy), 64'd1);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flushFix busy", 64'(busy), 64'd0);
    check("flushFix done", 64'(done), 64'd0);
    check("flushFix hi", 64'(hi), 64'hFFFF_FFFB);
    check("flushFix lo", 64'(lo), 64'hFFFF_FFFF);

    issue(3'd5, 32'h0000_1234, 32'd0);
    check("mtlo lo", 64'(lo), 64'h0000_1234);
    check("mtlo hi", 64'(hi), 64'hFFFF_FFFB);
    check("mtlo busy", 64'(busy), 64'd0);
    check("mtlo done", 64'(done), 64'd0);

    // MTHI suppressed by flush in IDLE
    @(negedge clk);
    flush = 1'b1;
    issue(3'd4, 32'h0000_5555, 32'd0);
    flush = 1'b0;
    check("idleFlush hi", 64'(hi), 64'hFFFF_FFFB);

    issue(3'd6, 32'h0000_7777, 32'd1);
    check("rsvd busy", 64'(busy), 64'd0);
    check("rsvd hi", 64'(hi), 64'hFFFF_FFFB);
    check("rsvd lo", 64'(lo), 64'h0000_1234);

    issue(3'd4, 32'h0000_AAAA, 32'd0);
    check("mthi hi", 64'(hi), 64'h0000_AAAA);

    // MTHI while busy, then async reset mid-RUN
    issue(3'd0, 32'd5, 32'd6);
    repeat (5) @(posedge clk);
    issue(3'd4, 32'h0000_BBBB, 32'd0);
    check("busyMthi hi", 64'(hi), 64'h0000_AAAA);
    check("busyMthi busy", 64'(busy), 64'd1);
    #2;
    resetN = 1'b0;
    #1;
    check("midRst busy", 64'(busy), 64'd0);
    check("midRst hi", 64'(hi), 64'd0);
    check("midRst lo", 64'(lo), 64'd0);
    check("midRst done", 64'(done), 64'd0);
    @(negedge clk);
    resetN = 1'b1;

    runOp("multu 5x6", 3'd1, 32'd5, 32'd6,
          32'd0, 32'd30);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
